// File: rtl/writeback_stage.sv
// Write-back stage of the RV32I pipeline. It holds the M/W register, extracts load data and drives the
// register-file write port. It also keeps a retired-instruction counter.
module writeback_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_W,
  input  logic                 flush_W,
  input  logic                 valid_M,
  input  logic                 regWrite_M,
  input  logic [1:0]           resultSrc_M,
  input  logic [4:0]           Rd_M,
  input  logic [WIDTH-1:0]     ALUresult_M,
  input  logic [WIDTH-1:0]     readData_M,
  input  logic [WIDTH-1:0]     PCPlus4_M,
  input  logic [2:0]           DMem_size_M,
  output logic                 regWrite_W,
  output logic [4:0]           Rd_W,
  output logic [WIDTH-1:0]     result_W,
  output logic                 valid_W,
  output logic [CNT_WIDTH-1:0] retired
);

  logic                 valid_p0;
  logic                 reg_write_p0;
  logic [1:0]           result_src_p0;
  logic [4:0]           rd_p0;
  logic [WIDTH-1:0]     alu_result_p0;
  logic [WIDTH-1:0]     read_data_p0;
  logic [WIDTH-1:0]     pc_plus4_p0;
  logic [2:0]           dmem_size_p0;
  logic [CNT_WIDTH-1:0] retired_q;
  logic [WIDTH-1:0]     load_data;
  logic [WIDTH-1:0]     result_mux;

  function automatic logic [WIDTH-1:0] load_extract(
    input logic [WIDTH-1:0] word,
    input logic [2:0]       size,
    input logic [1:0]       off
  );
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [WIDTH-1:0]   res;
    byte_s = word[{off, 3'b000} +: 8];
    half_s = word[{off[1], 4'b0000} +: 16];
    case (size)
      3'b000:  res = {{(WIDTH-8){byte_s[7]}}, byte_s};
      3'b100:  res = {{(WIDTH-8){1'b0}}, byte_s};
      3'b001:  res = {{(WIDTH-16){half_s[15]}}, half_s};
      3'b101:  res = {{(WIDTH-16){1'b0}}, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  // M -> W register: flush beats stall, reset clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_p0      <= 1'b0;
      reg_write_p0  <= 1'b0;
      result_src_p0 <= 2'b00;
      rd_p0         <= 5'd0;
      alu_result_p0 <= '0;
      read_data_p0  <= '0;
      pc_plus4_p0   <= '0;
      dmem_size_p0  <= 3'b000;
    end else if (flush_W) begin
      valid_p0      <= 1'b0;
      reg_write_p0  <= 1'b0;
      result_src_p0 <= 2'b00;
      rd_p0         <= 5'd0;
      alu_result_p0 <= '0;
      read_data_p0  <= '0;
      pc_plus4_p0   <= '0;
      dmem_size_p0  <= 3'b000;
    end else if (en_W) begin
      valid_p0      <= valid_M;
      reg_write_p0  <= regWrite_M;
      result_src_p0 <= resultSrc_M;
      rd_p0         <= Rd_M;
      alu_result_p0 <= ALUresult_M;
      read_data_p0  <= readData_M;
      pc_plus4_p0   <= PCPlus4_M;
      dmem_size_p0  <= DMem_size_M;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (!flush_W && en_W && valid_M) begin
      retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // W stage: combinational extraction and result select from the register
  always_comb begin
    load_data = load_extract(read_data_p0, dmem_size_p0, alu_result_p0[1:0]);
    case (result_src_p0)
      2'b01:   result_mux = load_data;
      2'b10:   result_mux = pc_plus4_p0;
      default: result_mux = alu_result_p0;
    endcase
  end

  assign regWrite_W = reg_write_p0 & valid_p0 & (rd_p0 != 5'd0);
  assign Rd_W       = rd_p0;
  assign result_W   = result_mux;
  assign valid_W    = valid_p0;
  assign retired    = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected outputs; a monitor pops and compares.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        en_W;
  logic        flush_W;
  logic        valid_M;
  logic        regWrite_M;
  logic [1:0]  resultSrc_M;
  logic [4:0]  Rd_M;
  logic [31:0] ALUresult_M;
  logic [31:0] readData_M;
  logic [31:0] PCPlus4_M;
  logic [2:0]  DMem_size_M;
  logic        regWrite_W;
  logic [4:0]  Rd_W;
  logic [31:0] result_W;
  logic        valid_W;
  logic [63:0] retired;

  logic        rst4;
  logic        en4;
  logic        valid4;
  logic        regWrite_W4;
  logic [4:0]  Rd_W4;
  logic [31:0] result_W4;
  logic        valid_W4;
  logic [3:0]  retired4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        vld;
    logic [63:0] ret;
    string       nm;
  } exp_t;

  exp_t sb[$];

  writeback_stage #(.WIDTH(32), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .en_W(en_W), .flush_W(flush_W), .valid_M(valid_M),
    .regWrite_M(regWrite_M), .resultSrc_M(resultSrc_M), .Rd_M(Rd_M),
    .ALUresult_M(ALUresult_M), .readData_M(readData_M), .PCPlus4_M(PCPlus4_M),
    .DMem_size_M(DMem_size_M), .regWrite_W(regWrite_W), .Rd_W(Rd_W),
    .result_W(result_W), .valid_W(valid_W), .retired(retired)
  );

  writeback_stage #(.WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en_W(en4), .flush_W(1'b0), .valid_M(valid4),
    .regWrite_M(1'b0), .resultSrc_M(2'b00), .Rd_M(5'd0),
    .ALUresult_M(32'd0), .readData_M(32'd0), .PCPlus4_M(32'd0),
    .DMem_size_M(3'b000), .regWrite_W(regWrite_W4), .Rd_W(Rd_W4),
    .result_W(result_W4), .valid_W(valid_W4), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare one expected output state per clock on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, ".regWrite_W"}, {63'd0, regWrite_W}, {63'd0, e.rw});
        chk({e.nm, ".Rd_W"},       {59'd0, Rd_W},       {59'd0, e.rd});
        chk({e.nm, ".result_W"},   {32'd0, result_W},   {32'd0, e.res});
        chk({e.nm, ".valid_W"},    {63'd0, valid_W},    {63'd0, e.vld});
        chk({e.nm, ".retired"},    retired,             e.ret);
      end
    end
  end

  task automatic step(
    input logic en, input logic fl, input logic vm, input logic rw,
    input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
    input logic [31:0] rdata, input logic [31:0] pc4, input logic [2:0] sz,
    input logic e_rw, input logic [4:0] e_rd, input logic [31:0] e_res,
    input logic e_vld, input logic [63:0] e_ret, input string nm
  );
    exp_t e;
    @(negedge clk);
    en_W = en; flush_W = fl; valid_M = vm; regWrite_M = rw; resultSrc_M = src;
    Rd_M = rd; ALUresult_M = alu; readData_M = rdata; PCPlus4_M = pc4; DMem_size_M = sz;
    @(posedge clk);
    e.rw = e_rw; e.rd = e_rd; e.res = e_res; e.vld = e_vld; e.ret = e_ret; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".regWrite_W"}, {63'd0, regWrite_W}, 64'd0);
    chk({nm, ".Rd_W"},       {59'd0, Rd_W},       64'd0);
    chk({nm, ".result_W"},   {32'd0, result_W},   64'd0);
    chk({nm, ".valid_W"},    {63'd0, valid_W},    64'd0);
    chk({nm, ".retired"},    retired,             64'd0);
  endtask

  localparam logic [31:0] RD = 32'h80F17F01;

  initial begin
    rst = 1'b0; rst4 = 1'b0; en4 = 1'b0; valid4 = 1'b0;
    en_W = 1'b0; flush_W = 1'b0; valid_M = 1'b0; regWrite_M = 1'b0; resultSrc_M = 2'b00;
    Rd_M = 5'd0; ALUresult_M = 32'd0; readData_M = 32'd0; PCPlus4_M = 32'd0; DMem_size_M = 3'b000;

    // reset then idle
    #3 check_zero("reset_t3");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    rst = 1'b1;
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000,
           0, 5'd0, 32'd0, 0, 64'd0, "idle");

    // load extraction
    step(1, 0, 1, 1, 2'b01, 5'd5, 32'h3, RD, 32'h0, 3'b000, 1, 5'd5, 32'hFFFFFF80, 1, 64'd1, "lb_off3");
    step(1, 0, 1, 1, 2'b01, 5'd5, 32'h3, RD, 32'h0, 3'b100, 1, 5'd5, 32'h00000080, 1, 64'd2, "lbu_off3");
    step(1, 0, 1, 1, 2'b01, 5'd5, 32'h2, RD, 32'h0, 3'b000, 1, 5'd5, 32'hFFFFFFF1, 1, 64'd3, "lb_off2");
    step(1, 0, 1, 1, 2'b01, 5'd5, 32'h2, RD, 32'h0, 3'b001, 1, 5'd5, 32'hFFFF80F1, 1, 64'd4, "lh_off2");
    step(1, 0, 1, 1, 2'b01, 5'd5, 32'h0, RD, 32'h0, 3'b101, 1, 5'd5, 32'h00007F01, 1, 64'd5, "lhu_off0");
    step(1, 0, 1, 1, 2'b01, 5'd5, 32'h1, RD, 32'h0, 3'b010, 1, 5'd5, 32'h80F17F01, 1, 64'd6, "lw_off1");

    // result select and x0
    step(1, 0, 1, 1, 2'b00, 5'd6, 32'h1234, 32'h0, 32'h104, 3'b010, 1, 5'd6, 32'h1234, 1, 64'd7, "src00");
    step(1, 0, 1, 1, 2'b10, 5'd6, 32'h1234, 32'h0, 32'h104, 3'b010, 1, 5'd6, 32'h104, 1, 64'd8, "src10");
    step(1, 0, 1, 1, 2'b11, 5'd6, 32'h1234, 32'h0, 32'h104, 3'b010, 1, 5'd6, 32'h1234, 1, 64'd9, "src11");
    step(1, 0, 1, 1, 2'b00, 5'd0, 32'h1234, 32'h0, 32'h104, 3'b010, 0, 5'd0, 32'h1234, 1, 64'd10, "x0");

    // stall then flush with en low
    step(1, 0, 1, 1, 2'b00, 5'd7, 32'hAAAA, 32'h0, 32'h0, 3'b010, 1, 5'd7, 32'hAAAA, 1, 64'd11, "cap7");
    step(0, 0, 1, 1, 2'b10, 5'd9, 32'h1111, 32'h0, 32'h200, 3'b010, 1, 5'd7, 32'hAAAA, 1, 64'd11, "stall1");
    step(0, 0, 1, 1, 2'b01, 5'd10, 32'h2222, 32'hFFFF, 32'h300, 3'b000, 1, 5'd7, 32'hAAAA, 1, 64'd11, "stall2");
    step(0, 0, 1, 0, 2'b00, 5'd11, 32'h3333, 32'h0, 32'h400, 3'b010, 1, 5'd7, 32'hAAAA, 1, 64'd11, "stall3");
    step(0, 1, 1, 1, 2'b00, 5'd12, 32'h4444, 32'h0, 32'h0, 3'b010, 0, 5'd0, 32'h0, 0, 64'd11, "flush_stall");

    // counter: restart from reset, 10 valid instructions, 2 flushed, 3 stalls
    @(negedge clk); rst = 1'b0;
    #1 check_zero("reset2");
    @(negedge clk); rst = 1'b1;
    step(1, 0, 1, 1, 2'b00, 5'd1, 32'h101, 0, 0, 3'b010, 1, 5'd1, 32'h101, 1, 64'd1, "i1");
    step(1, 0, 1, 1, 2'b00, 5'd2, 32'h102, 0, 0, 3'b010, 1, 5'd2, 32'h102, 1, 64'd2, "i2");
    step(1, 1, 1, 1, 2'b00, 5'd3, 32'h103, 0, 0, 3'b010, 0, 5'd0, 32'h0, 0, 64'd2, "i3_flush");
    step(1, 0, 1, 1, 2'b00, 5'd4, 32'h104, 0, 0, 3'b010, 1, 5'd4, 32'h104, 1, 64'd3, "i4");
    step(0, 0, 1, 1, 2'b00, 5'd31, 32'hDEAD, 0, 0, 3'b010, 1, 5'd4, 32'h104, 1, 64'd3, "stall_a");
    step(1, 0, 1, 1, 2'b00, 5'd5, 32'h105, 0, 0, 3'b010, 1, 5'd5, 32'h105, 1, 64'd4, "i5");
    step(1, 1, 1, 1, 2'b00, 5'd6, 32'h106, 0, 0, 3'b010, 0, 5'd0, 32'h0, 0, 64'd4, "i6_flush");
    step(0, 0, 1, 1, 2'b00, 5'd31, 32'hBEEF, 0, 0, 3'b010, 0, 5'd0, 32'h0, 0, 64'd4, "stall_b");
    step(0, 0, 1, 1, 2'b00, 5'd30, 32'hCAFE, 0, 0, 3'b010, 0, 5'd0, 32'h0, 0, 64'd4, "stall_c");
    step(1, 0, 1, 1, 2'b00, 5'd7, 32'h107, 0, 0, 3'b010, 1, 5'd7, 32'h107, 1, 64'd5, "i7");
    step(1, 0, 1, 1, 2'b00, 5'd8, 32'h108, 0, 0, 3'b010, 1, 5'd8, 32'h108, 1, 64'd6, "i8");
    step(1, 0, 1, 1, 2'b00, 5'd9, 32'h109, 0, 0, 3'b010, 1, 5'd9, 32'h109, 1, 64'd7, "i9");
    step(1, 0, 1, 1, 2'b00, 5'd10, 32'h10A, 0, 0, 3'b010, 1, 5'd10, 32'h10A, 1, 64'd8, "i10");

    // async reset mid-stream while a write is pending
    step(1, 0, 1, 1, 2'b00, 5'd3, 32'h55, 0, 0, 3'b010, 1, 5'd3, 32'h55, 1, 64'd9, "pre_async");
    @(negedge clk);
    #2 rst = 1'b0; en_W = 1'b0; valid_M = 1'b0;
    #1 check_zero("async_rst");
    #1 rst = 1'b1;
    step(1, 0, 1, 1, 2'b00, 5'd2, 32'h77, 0, 0, 3'b010, 1, 5'd2, 32'h77, 1, 64'd1, "post_async");

    // wrap of a 4-bit counter
    @(negedge clk); rst4 = 1'b1; en4 = 1'b1; valid4 = 1'b1;
    repeat (15) @(negedge clk);
    chk("cnt4_all_ones", {60'd0, retired4}, 64'hF);
    @(negedge clk);
    chk("cnt4_wrap", {60'd0, retired4}, 64'h0);
    en4 = 1'b0;
    chk("cnt4_valid_W", {63'd0, valid_W4}, 64'd1);
    chk("cnt4_regWrite_W", {63'd0, regWrite_W4}, 64'd0);
    chk("cnt4_Rd_W", {59'd0, Rd_W4}, 64'd0);
    chk("cnt4_result_W", {32'd0, result_W4}, 64'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
